// File: rtl/cdc_sched_pkg.sv
// -----------------------------------------------------------------------------
// cdc_sched_pkg
// Shared types and helpers for the CDC transfer scheduler.
//   state_t    : FSM state encoding (IDLE, REQ, DROP)
//   CNT_W      : width of the completed-transfer counter
//   MAX_REQ    : widest requester vector the select helper can handle
//   rr_onehot  : round-robin one-hot winner search starting at a pointer
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

package cdc_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t DROP = 2'd2;

    localparam int CNT_W   = 8;
    localparam int MAX_REQ = 32;

    // Returns a one-hot vector marking the first set bit of valid found by
    // searching upward from ptr, wrapping at n. Zero when nothing is valid.
    function automatic logic [MAX_REQ-1:0] rr_onehot(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] sel;
        logic               found;
        int                 idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (!found && (k < n) && valid[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cdc_xfer_scheduler_sync.sv
// -----------------------------------------------------------------------------
// cdc_ack_sync
// NUM_STAGES-deep flop chain bringing the destination ack into the source
// clock domain. The output follows the input exactly NUM_STAGES edges later.
// Ports:
//   CLK_source_count : source clock
//   RST_counter      : asynchronous active-low clear of the whole chain
//   ack_async_i      : unsynchronized ack from the destination
//   ack_sync_o       : synchronized ack (last flop of the chain)
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module cdc_ack_sync #(
    parameter int unsigned NUM_STAGES = 3
) (
    input  logic CLK_source_count,
    input  logic RST_counter,
    input  logic ack_async_i,
    output logic ack_sync_o
);

    logic [NUM_STAGES-1:0] sync_q;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // previous stage's old value; blocking here would collapse the chain.
    always_ff @(posedge CLK_source_count or negedge RST_counter) begin
        if (!RST_counter) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], ack_async_i};
        end
    end

    assign ack_sync_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_xfer_scheduler.sv
// -----------------------------------------------------------------------------
// cdc_xfer_scheduler
// Source-domain controller sharing one req/ack CDC channel among NUM_REQ
// requesters: round-robin arbitration, payload capture and a 4-phase
// handshake (req up, ack up, req down, ack down) with the destination.
//
// Optional feature: define CDC_TIMEOUT_EN to add a handshake watchdog that
// abandons a stuck REQ or DROP phase after TIMEOUT_CYCLES and sets the sticky
// timeout_err flag. Without it the FSM waits indefinitely and timeout_err is 0.
//
// Ports:
//   CLK_source_count : source clock, all logic on posedge
//   RST_counter      : asynchronous active-low reset
//   req_valid        : per-requester valid, held until accepted
//   req_data         : packed payloads, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   req_ready        : one-hot accept, only asserted in IDLE
//   xfer_req         : registered level request to the destination
//   xfer_data        : registered payload, stable for the whole handshake
//   xfer_ack_async   : destination ack, unsynchronized
//   grant_id         : index of the last accepted requester
//   busy             : high whenever the FSM is not IDLE
//   xfer_count       : completed transfers, wraps 255 -> 0
//   timeout_err      : sticky watchdog flag
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module cdc_xfer_scheduler
    import cdc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                           CLK_source_count,
    input  logic                           RST_counter,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           xfer_req,
    output logic [BUS_WIDTH-1:0]           xfer_data,
    input  logic                           xfer_ack_async,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic [CNT_W-1:0]               xfer_count,
    output logic                           timeout_err
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic                 ack_s;

    state_t               state_q,    state_d;
    logic [PTR_W-1:0]     ptr_q,      ptr_d;
    logic [BUS_WIDTH-1:0] data_q,     data_d;
    logic [PTR_W-1:0]     grant_q,    grant_d;
    logic                 xfer_req_q, xfer_req_d;
    logic [CNT_W-1:0]     count_q,    count_d;

    logic [NUM_REQ-1:0]   winner_oh;
    logic [PTR_W-1:0]     winner_idx;
    logic [BUS_WIDTH-1:0] winner_data;
    logic                 grant_ok;
    logic                 timeout_hit;
    logic                 count_inhibit;

    cdc_ack_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK_source_count (CLK_source_count),
        .RST_counter      (RST_counter),
        .ack_async_i      (xfer_ack_async),
        .ack_sync_o       (ack_s)
    );

    // ---------------------------------------------------------------- arbiter
    assign winner_oh = NUM_REQ'(rr_onehot(MAX_REQ'(req_valid), int'(ptr_q), int'(NUM_REQ)));

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        winner_idx  = '0;
        winner_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner_oh[i]) begin
                winner_idx  = PTR_W'(i);
                winner_data = req_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // A stale or lingering ack must drain before a new request may start.
    assign grant_ok = (state_q == IDLE) && (|req_valid) && !ack_s;

    // -------------------------------------------------------------------- FSM
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        grant_d    = grant_q;
        xfer_req_d = xfer_req_q;
        count_d    = count_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    req_ready  = winner_oh;
                    data_d     = winner_data;
                    grant_d    = winner_idx;
                    ptr_d      = (winner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : winner_idx + 1'b1;
                    xfer_req_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (ack_s || timeout_hit) begin
                    xfer_req_d = 1'b0;
                    state_d    = DROP;
                end
            end
            DROP: begin
                if (!ack_s) begin
                    // A request abandoned by the watchdog is not a completion.
                    if (!count_inhibit) count_d = count_q + 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                xfer_req_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_source_count or negedge RST_counter) begin
        if (!RST_counter) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            data_q     <= '0;
            grant_q    <= '0;
            xfer_req_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            xfer_req_q <= xfer_req_d;
            count_q    <= count_d;
        end
    end

    // --------------------------------------------------------------- watchdog
`ifdef CDC_TIMEOUT_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES + 1) > CNT_W) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : CNT_W;

    logic [WD_W-1:0] wd_q,    wd_d;
    logic            err_q,   err_d;
    logic            abort_q, abort_d;
    logic            wd_expired;

    assign wd_expired  = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    // Only a phase that is actually stuck times out; a same-cycle ack wins.
    assign timeout_hit = wd_expired &&
                         (((state_q == REQ) && !ack_s) || ((state_q == DROP) && ack_s));

    always_comb begin
        // Restart on every state change so REQ and DROP each get a full budget.
        wd_d    = ((state_d != state_q) || (state_q == IDLE)) ? '0 : wd_q + 1'b1;
        err_d   = err_q | timeout_hit;
        abort_d = abort_q;
        if (state_q == IDLE) begin
            abort_d = 1'b0;
        end else if ((state_q == REQ) && timeout_hit) begin
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_source_count or negedge RST_counter) begin
        if (!RST_counter) begin
            wd_q    <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign timeout_err   = err_q;
    assign count_inhibit = abort_q;
`else
    assign timeout_hit   = 1'b0;
    assign count_inhibit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // ---------------------------------------------------------------- outputs
    assign xfer_req   = xfer_req_q;
    assign xfer_data  = data_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
    assign xfer_count = count_q;

endmodule
